// File: rtl/audio_pkg.sv
// Shared types for the audio rate adapter: stereo sample word and control states.
package audio_pkg;

  typedef struct packed {
    logic signed [15:0] left;
    logic signed [15:0] right;
  } stereo_t;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push at full and pop at empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (level == (AW+1)'(DEPTH));
    empty   = (level == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    rdata   = mem[rd_ptr];
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/audio_rate_adapter.sv
// Buffers producer stereo samples and releases them at exactly RATE_HZ using a
// fractional accumulator on the single system clock.
module audio_rate_adapter
  import audio_pkg::*;
#(
  parameter int CLK_HZ  = 32000000,
  parameter int RATE_HZ = 48000,
  parameter int DEPTH   = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            in_left,
  input  logic [15:0]            in_right,
  input  logic                   mute,
  output logic [15:0]            out_left,
  output logic [15:0]            out_right,
  output logic                   out_strobe,
  output logic [$clog2(DEPTH):0] level,
  output logic                   underrun
);

  localparam int ACC_W = $clog2(CLK_HZ) + 1;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic             tick;

  state_t  state;
  state_t  state_next;
  stereo_t wr_sample;
  stereo_t rd_sample;
  logic    full;
  logic    empty;
  logic    push;
  logic    pop;
  logic    starve;
  logic [LW-1:0] level_next;

  always_comb begin
    acc_sum = acc + ACC_W'(RATE_HZ);
    tick    = (acc_sum >= ACC_W'(CLK_HZ));
  end

  always_ff @(posedge clk) begin
    if (!resetn)   acc <= '0;
    else if (tick) acc <= acc_sum - ACC_W'(CLK_HZ);
    else           acc <= acc_sum;
  end

  always_comb begin
    in_ready   = !full;
    wr_sample  = '{left: in_left, right: in_right};
    push       = in_valid && in_ready;
    pop        = tick && (state == RUN) && !empty;
    starve     = tick && (state == RUN) && empty;
    level_next = level + LW'(push) - LW'(pop);
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .wdata  (wr_sample),
    .rdata  (rd_sample),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

  // Priming threshold looks at the occupancy after this cycle's write lands.
  always_comb begin
    state_next = state;
    case (state)
      PRIME:   if (level_next >= LW'(DEPTH / 2)) state_next = RUN;
      RUN:     if (starve) state_next = PRIME;
      default: state_next = PRIME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= PRIME;
      out_left   <= '0;
      out_right  <= '0;
      out_strobe <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_next;
      out_strobe <= tick;
      if (starve) underrun <= 1'b1;
      if (tick) begin
        if (mute) begin
          out_left  <= '0;
          out_right <= '0;
        end else if (pop) begin
          out_left  <= rd_sample.left;
          out_right <= rd_sample.right;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_rate_adapter.sv
// Self-checking bench: queue-based reference model plus directed and random stimulus.
module tb_audio_rate_adapter;

  localparam int CLK_HZ  = 32000;
  localparam int RATE_HZ = 48;
  localparam int DEPTH   = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_left;
  logic [15:0] in_right;
  logic        mute;
  logic [15:0] out_left;
  logic [15:0] out_right;
  logic        out_strobe;
  logic [4:0]  level;
  logic        underrun;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  audio_rate_adapter #(
    .CLK_HZ  (CLK_HZ),
    .RATE_HZ (RATE_HZ),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_left    (in_left),
    .in_right   (in_right),
    .mute       (mute),
    .out_left   (out_left),
    .out_right  (out_right),
    .out_strobe (out_strobe),
    .level      (level),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tick k fires when floor(k*R/C) advances; FIFO is a queue.
  logic [31:0] q[$];
  bit          m_run;
  logic [15:0] m_l, m_r;
  bit          m_strobe, m_under;
  longint      m_k;

  always @(posedge clk) begin
    bit tick, acc_w, popn, starve;
    if (!resetn) begin
      q.delete();
      m_run = 0; m_l = '0; m_r = '0; m_strobe = 0; m_under = 0; m_k = 0;
    end else begin
      m_k++;
      tick   = ((m_k * RATE_HZ) / CLK_HZ) != (((m_k - 1) * RATE_HZ) / CLK_HZ);
      acc_w  = in_valid && (q.size() != DEPTH);
      popn   = tick && m_run && (q.size() != 0);
      starve = tick && m_run && (q.size() == 0);
      m_strobe = tick;
      if (tick) begin
        if (mute) begin
          m_l = '0; m_r = '0;
        end else if (popn) begin
          m_l = q[0][31:16]; m_r = q[0][15:0];
        end
      end
      if (popn)  void'(q.pop_front());
      if (acc_w) q.push_back({in_left, in_right});
      if (starve) begin
        m_under = 1; m_run = 0;
      end else if (!m_run && q.size() >= DEPTH / 2) begin
        m_run = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("level",      level,      q.size());
      check("in_ready",   in_ready,   q.size() != DEPTH);
      check("out_strobe", out_strobe, m_strobe);
      check("out_left",   out_left,   m_l);
      check("out_right",  out_right,  m_r);
      check("underrun",   underrun,   m_under);
    end
  end

  task automatic pulse_reset();
    @(negedge clk) resetn = 1'b0;
    @(negedge clk) resetn = 1'b1;
  endtask

  task automatic wait_strobe(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_strobe && n < 2000);
    check(tag, out_strobe, 1);
  endtask

  initial begin
    int cnt, last, dens;
    resetn = 1'b0; in_valid = 1'b0; mute = 1'b0; in_left = '0; in_right = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    resetn = 1'b1;

    check("rst_level", level, 0);
    check("rst_ready", in_ready, 1);
    check("rst_left", out_left, 0);
    check("rst_right", out_right, 0);
    check("rst_underrun", underrun, 0);

    // Exact rate: 48 strobes in 32000 clocks, spacing 666/667
    cnt = 0; last = -1;
    for (int i = 0; i < CLK_HZ; i++) begin
      @(negedge clk);
      if (out_strobe) begin
        if (last >= 0) check("spacing", (i - last == 666) || (i - last == 667), 1);
        last = i; cnt++;
      end
    end
    check("strobe_count", cnt, RATE_HZ);

    // Priming with 8 samples, ordered playback, then underrun
    pulse_reset();
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_left = 16'(i); in_right = 16'h8000 + 16'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("prime_level", level, 8);
    wait_strobe("strobe1");
    check("first_left", out_left, 16'h0001);
    check("first_right", out_right, 16'h8001);
    wait_strobe("strobe2");
    check("second_left", out_left, 16'h0002);
    check("second_right", out_right, 16'h8002);
    for (int i = 0; i < 6; i++) wait_strobe("drain");
    check("drained_level", level, 0);
    wait_strobe("starve_strobe");
    check("hold_left", out_left, 16'h0008);
    check("hold_right", out_right, 16'h8008);
    check("underrun_set", underrun, 1);

    // Fill to full before any tick
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_left = 16'(i); in_right = ~16'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("full_level", level, 16);
    check("full_ready", in_ready, 0);

    // Mute while draining
    for (int i = 0; i < 10 && level != 10; i++) wait_strobe("to_ten");
    check("level_ten", level, 10);
    mute = 1'b1;
    wait_strobe("mute_strobe");
    check("mute_left", out_left, 0);
    check("mute_right", out_right, 0);
    check("mute_level", level, 9);
    mute = 1'b0;
    wait_strobe("unmute_strobe");
    check("unmute_left", out_left, 16'h0007);
    check("unmute_right", out_right, 16'hfff8);

    // Reset with 12 entries resident
    in_valid = 1'b1;
    for (int i = 0; i < 50 && level < 12; i++) @(negedge clk);
    in_valid = 1'b0;
    check("pre_reset_level", level, 12);
    pulse_reset();
    check("post_reset_level", level, 0);
    check("post_reset_left", out_left, 0);
    check("post_reset_right", out_right, 0);
    check("post_reset_ready", in_ready, 1);
    check("post_reset_underrun", underrun, 0);

    // Randomized traffic with varying producer density
    dens = 50;
    for (int i = 0; i < 20000; i++) begin
      if (i % 2000 == 0) begin
        case ($urandom_range(0, 4))
          0: dens = 0;
          1: dens = 1;
          2: dens = 5;
          default: dens = 50;
        endcase
      end
      @(negedge clk);
      if ($urandom_range(0, 3999) == 0) resetn = 1'b0;
      else resetn = 1'b1;
      in_valid = ($urandom_range(0, 99) < dens);
      in_left  = 16'($urandom);
      in_right = 16'($urandom);
      mute     = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    resetn = 1'b1; in_valid = 1'b0; mute = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
